move_scheduler: RTL and testbench

Sequences all updates to the player position register (12-bit loadable, {y,x}) and the move counter register (8-bit, increments on Load) in the maze game. Two requesters share them: the human input path (requester 0) and the AI solver (requester 1). Arbitration between them is round-robin. Each granted move is bounds-checked and wall-checked through a one-outstanding query port to the maze map. Only legal moves are committed, and the block issues the Load/D and increment strobes for both registers.

---
 rtl/move_scheduler.sv | 141 ++++++++++++++
 tb/tb_move_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// move_scheduler: round-robin arbiter and sequencer for player position and
// move counter updates. Each granted move is bounds/saturation checked, then
// wall-checked through a single-outstanding map query before being committed.
module move_scheduler #(
  parameter int COORD_W  = 6,
  parameter int MAX_X    = 39,
  parameter int MAX_Y    = 29,
  parameter int WAIT_MAX = 15
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [1:0]           req,
  input  logic [1:0]           dir0,
  input  logic [1:0]           dir1,
  input  logic [2*COORD_W-1:0] pos_q,
  input  logic [7:0]           moves_q,
  output logic                 wall_rd,
  output logic [2*COORD_W-1:0] wall_addr,
  input  logic                 wall_rdy,
  input  logic                 wall_hit,
  output logic                 pos_load,
  output logic [2*COORD_W-1:0] pos_d,
  output logic                 moves_inc,
  output logic [1:0]           ack,
  output logic                 accepted,
  output logic                 busy
);

  localparam int TW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_QUERY, S_WAIT, S_COMMIT, S_ACK
  } state_t;

  state_t               state, next;
  logic                 grant, last_grant, gsel, do_grant, reject;
  logic [1:0]           mask, eff;
  logic [1:0]           dir_r;
  logic [2*COORD_W-1:0] pos_r, cand, cand_next;
  logic [COORD_W-1:0]   x_r, y_r;
  logic                 ok;
  logic [TW-1:0]        tcnt;

  assign x_r = pos_r[COORD_W-1:0];
  assign y_r = pos_r[2*COORD_W-1:COORD_W];

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next;
  end

  // Grant bookkeeping, latched move, candidate, verdict and wait timer
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      mask       <= '0;
      dir_r      <= '0;
      pos_r      <= '0;
      cand       <= '0;
      ok         <= 1'b0;
      tcnt       <= '0;
    end else begin
      // the requester just acked is ignored for exactly the following cycle
      mask <= (state == S_ACK) ? (grant ? 2'b10 : 2'b01) : 2'b00;
      case (state)
        S_IDLE: if (do_grant) begin
          grant      <= gsel;
          last_grant <= gsel;
          dir_r      <= gsel ? dir1 : dir0;
          pos_r      <= pos_q;
        end
        S_CALC: begin
          cand <= cand_next;
          ok   <= 1'b0;
        end
        S_QUERY:  tcnt <= '0;
        S_WAIT:   if (!wall_rdy) tcnt <= tcnt + TW'(1);
        S_COMMIT: ok <= 1'b1;
        default: ;
      endcase
    end
  end

  // Arbitration, candidate/limit checks, next state and state-decoded outputs
  always_comb begin
    next      = state;
    do_grant  = 1'b0;
    reject    = 1'b0;
    cand_next = pos_r;
    eff       = req & ~mask;
    gsel      = (eff == 2'b11) ? ~last_grant : eff[1];

    case (dir_r)
      2'b00: begin
        cand_next[2*COORD_W-1:COORD_W] = y_r - COORD_W'(1);
        reject = (y_r == '0);
      end
      2'b01: begin
        cand_next[2*COORD_W-1:COORD_W] = y_r + COORD_W'(1);
        reject = (y_r == COORD_W'(MAX_Y));
      end
      2'b10: begin
        cand_next[COORD_W-1:0] = x_r - COORD_W'(1);
        reject = (x_r == '0);
      end
      default: begin
        cand_next[COORD_W-1:0] = x_r + COORD_W'(1);
        reject = (x_r == COORD_W'(MAX_X));
      end
    endcase
    if (moves_q == 8'hFF) reject = 1'b1;

    case (state)
      S_IDLE: if (|eff) begin
        do_grant = 1'b1;
        next     = S_CALC;
      end
      S_CALC:  next = reject ? S_ACK : S_QUERY;
      S_QUERY: next = S_WAIT;
      S_WAIT: begin
        if (wall_rdy)                           next = wall_hit ? S_ACK : S_COMMIT;
        else if (tcnt == TW'(WAIT_MAX - 1))     next = S_ACK;
      end
      S_COMMIT: next = S_ACK;
      S_ACK:    next = S_IDLE;
      default:  next = S_IDLE;
    endcase

    busy      = (state != S_IDLE);
    wall_rd   = (state == S_QUERY);
    wall_addr = (state == S_QUERY || state == S_WAIT) ? cand : '0;
    pos_load  = (state == S_COMMIT);
    moves_inc = (state == S_COMMIT);
    pos_d     = (state == S_COMMIT) ? cand : '0;
    ack       = (state == S_ACK) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    accepted  = (state == S_ACK) && ok;
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: stimulus pushes expected acks, wall
// queries and commits (with their cycle numbers); a negedge monitor pops and
// compares whenever the DUT strobes.
module tb_move_scheduler;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  req = '0, dir0 = '0, dir1 = '0;
  logic [11:0] pos_q = '0;
  logic [7:0]  moves_q = '0;
  logic        wall_rd, wall_rdy = 1'b0, wall_hit = 1'b0;
  logic [11:0] wall_addr, pos_d;
  logic        pos_load, moves_inc, accepted, busy;
  logic [1:0]  ack;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  a;
    logic        acc;
    logic [11:0] addr;
    int          cyc;
  } exp_t;

  exp_t aq[$];
  exp_t qq[$];
  exp_t cq[$];

  move_scheduler #(.COORD_W(6), .MAX_X(39), .MAX_Y(29), .WAIT_MAX(15)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .dir0(dir0), .dir1(dir1),
    .pos_q(pos_q), .moves_q(moves_q), .wall_rd(wall_rd), .wall_addr(wall_addr),
    .wall_rdy(wall_rdy), .wall_hit(wall_hit), .pos_load(pos_load), .pos_d(pos_d),
    .moves_inc(moves_inc), .ack(ack), .accepted(accepted), .busy(busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every DUT strobe
  always @(negedge Clk) begin
    exp_t e;
    if (ack != 2'b00) begin
      if (aq.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
      else begin
        e = aq.pop_front();
        chk("ack", 32'(ack), 32'(e.a));
        chk("accepted", 32'(accepted), 32'(e.acc));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (wall_rd) begin
      if (qq.size() == 0) chk("unexpected_wall_rd", 32'(wall_rd), 32'd0);
      else begin
        e = qq.pop_front();
        chk("wall_addr", 32'(wall_addr), 32'(e.addr));
        chk("wall_rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (pos_load || moves_inc) begin
      if (cq.size() == 0) chk("unexpected_pos_load", 32'({pos_load, moves_inc}), 32'd0);
      else begin
        e = cq.pop_front();
        chk("pos_d", 32'(pos_d), 32'(e.addr));
        chk("moves_inc", 32'({pos_load, moves_inc}), 32'b11);
        chk("commit_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One move: lat = ack cycles after the grant edge; rd = wall_rdy delay into WAIT (-1: never)
  task automatic move(input logic [1:0] r, input logic [11:0] p, input logic [7:0] m,
                      input logic [1:0] d0, input logic [1:0] d1,
                      input logic [1:0] ea, input logic eacc, input int lat,
                      input bit q, input logic [11:0] cand, input int rd, input logic hit);
    int e;
    @(negedge Clk);
    pos_q = p; moves_q = m; dir0 = d0; dir1 = d1; req = r;
    e = cyc + 1;
    aq.push_back('{ea, eacc, 12'h000, e + lat});
    if (q)    qq.push_back('{2'b00, 1'b0, cand, e + 1});
    if (eacc) cq.push_back('{2'b00, 1'b1, cand, e + 3 + rd});
    if (rd >= 0) begin
      while (cyc < e + 2 + rd) @(negedge Clk);
      dir0 = ~d0; dir1 = ~d1;  // changes after grant must be ignored
      wall_hit = hit; wall_rdy = 1'b1;
      @(negedge Clk);
      wall_rdy = 1'b0; wall_hit = 1'b0;
    end
    while (cyc < e + lat) @(negedge Clk);
    req = '0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic chk_idle_zero(input string name);
    chk(name, 32'({wall_rd, wall_addr, pos_load, pos_d, moves_inc, ack, accepted, busy}), 32'd0);
  endtask

  initial begin
    int e;
    repeat (3) @(negedge Clk);
    chk_idle_zero("reset_outputs");
    Reset = 1'b0;
    @(negedge Clk);

    // Round-robin with both requests held: 0,1,0,1 (all boundary rejects)
    pos_q = 12'h000; moves_q = 8'h00; dir0 = 2'b00; dir1 = 2'b10; req = 2'b11;
    e = cyc + 1;
    aq.push_back('{2'b01, 1'b0, 12'h000, e + 1});
    aq.push_back('{2'b10, 1'b0, 12'h000, e + 4});
    aq.push_back('{2'b01, 1'b0, 12'h000, e + 7});
    aq.push_back('{2'b10, 1'b0, 12'h000, e + 10});
    while (cyc < e + 10) @(negedge Clk);
    req = '0;
    repeat (3) @(negedge Clk);

    // Single legal move (y=3,x=5) right
    move(2'b01, 12'h0C5, 8'h00, 2'b11, 2'b00, 2'b01, 1'b1, 4, 1'b1, 12'h0C6, 0, 1'b0);
    // Boundary rejects: up at y=0, right at x=39 (req 1), down at y=29
    move(2'b01, 12'h000, 8'h00, 2'b00, 2'b00, 2'b01, 1'b0, 1, 1'b0, 12'h000, -1, 1'b0);
    move(2'b10, 12'h2A7, 8'h00, 2'b00, 2'b11, 2'b10, 1'b0, 1, 1'b0, 12'h000, -1, 1'b0);
    move(2'b01, 12'h745, 8'h00, 2'b01, 2'b00, 2'b01, 1'b0, 1, 1'b0, 12'h000, -1, 1'b0);
    // Wall hit, response one cycle into WAIT
    move(2'b01, 12'h0C5, 8'h10, 2'b00, 2'b00, 2'b01, 1'b0, 4, 1'b1, 12'h085, 1, 1'b1);
    // Timeout: no wall_rdy, ack after WAIT_MAX WAIT cycles
    move(2'b10, 12'h145, 8'h10, 2'b00, 2'b10, 2'b10, 1'b0, 17, 1'b1, 12'h144, -1, 1'b0);
    // Legal from far corner with late response
    move(2'b01, 12'h767, 8'h20, 2'b10, 2'b00, 2'b01, 1'b1, 6, 1'b1, 12'h766, 2, 1'b0);
    // Saturation reject and last legal count
    move(2'b01, 12'h0C5, 8'hFF, 2'b11, 2'b00, 2'b01, 1'b0, 1, 1'b0, 12'h000, -1, 1'b0);
    move(2'b01, 12'h0C5, 8'hFE, 2'b01, 2'b00, 2'b01, 1'b1, 4, 1'b1, 12'h105, 0, 1'b0);
    // Tie after requester 0 was last granted: requester 1 wins
    move(2'b11, 12'h000, 8'h00, 2'b00, 2'b10, 2'b10, 1'b0, 1, 1'b0, 12'h000, -1, 1'b0);

    // Held req: requester 0 masked for one cycle after its ack
    @(negedge Clk);
    pos_q = 12'h000; dir0 = 2'b00; req = 2'b01;
    e = cyc + 1;
    aq.push_back('{2'b01, 1'b0, 12'h000, e + 1});
    aq.push_back('{2'b01, 1'b0, 12'h000, e + 5});
    while (cyc < e + 5) @(negedge Clk);
    req = '0;
    repeat (3) @(negedge Clk);

    // Reset mid-WAIT: requester 0 granted last, then aborted
    pos_q = 12'h0C5; moves_q = 8'h00; dir0 = 2'b11; req = 2'b01;
    e = cyc + 1;
    qq.push_back('{2'b00, 1'b0, 12'h0C6, e + 1});
    while (cyc < e + 3) @(negedge Clk);
    chk("busy_in_wait", 32'(busy), 32'd1);
    #2 Reset = 1'b1;
    #1 chk_idle_zero("reset_mid_wait");
    req = '0;
    @(negedge Clk);
    wall_rdy = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    wall_rdy = 1'b0;
    repeat (2) @(negedge Clk);
    chk_idle_zero("idle_after_reset");

    // Tie after reset goes to requester 0
    move(2'b11, 12'h0C5, 8'h00, 2'b11, 2'b00, 2'b01, 1'b1, 4, 1'b1, 12'h0C6, 0, 1'b0);

    repeat (4) @(negedge Clk);
    chk("acks_outstanding", 32'(aq.size()), 32'd0);
    chk("queries_outstanding", 32'(qq.size()), 32'd0);
    chk("commits_outstanding", 32'(cq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
